uart_tx_fifo: RTL and testbench

AXI-Stream-to-serial UART transmitter with an internal transmit FIFO. It is the transmit-side counterpart to the UART receiver.
- Accepts bytes on an AXIS slave port, buffers them, and serialises 8N1/8E1/8O1/8x2 frames onto tx_bit.
- Used wherever the fabric must send bursts faster than line rate without stalling the producer every byte.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types, parity encodings and baud divisor helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Rounded divisor so the bit period error stays within half a clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO with registered level.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_level == c_lvl_w'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : AXI-Stream fed UART transmitter with transmit FIFO (8N1/8E1/8O1/8x2).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 125_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 16,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            s_axis_tvalid,
  input  logic [7:0]                      s_axis_tdata,
  output logic                            s_axis_tready,
  output logic                            tx_bit,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int c_clks_per_bit = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int c_timer_w      = $clog2(c_clks_per_bit * 2);
  localparam logic [c_timer_w-1:0] c_bit_last  = c_timer_w'(c_clks_per_bit - 1);
  localparam logic [c_timer_w-1:0] c_stop_last = c_timer_w'(STOP_BITS * c_clks_per_bit - 1);

  if (c_clks_per_bit < 2) begin : g_chk_cpb
    $error("uart_tx_fifo: clocks per bit must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_chk_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
  end

  tx_state_e            r_state, w_state_nxt;
  logic [c_timer_w-1:0] r_timer, w_timer_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_tx_bit, w_tx_bit_nxt;
  logic                 r_busy, w_busy_nxt;

  logic       w_push;
  logic       w_pop;
  logic       w_load;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_fifo_dout;

  assign s_axis_tready = !w_full && !s_axis_areset;
  assign w_push        = s_axis_tvalid && s_axis_tready;
  assign tx_bit        = r_tx_bit;
  assign tx_busy       = r_busy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (s_axis_aclk),
    .rst    (s_axis_areset),
    .push   (w_push),
    .i_data (s_axis_tdata),
    .pop    (w_pop),
    .o_data (w_fifo_dout),
    .full   (w_full),
    .empty  (w_empty),
    .level  (fifo_level)
  );

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state   <= TX_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx_bit  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_tx_bit  <= w_tx_bit_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // A byte is loaded from IDLE or straight out of STOP so frames run back to back.
  assign w_load = !w_empty &&
                  ((r_state == TX_IDLE) || ((r_state == TX_STOP) && (r_timer == c_stop_last)));
  assign w_pop  = w_load;

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_tx_bit_nxt  = r_tx_bit;
    w_busy_nxt    = r_busy;

    case (r_state)
      TX_IDLE: begin
        w_timer_nxt  = '0;
        w_tx_bit_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
      end
      TX_START: begin
        if (r_timer == c_bit_last) begin
          w_state_nxt   = TX_DATA;
          w_timer_nxt   = '0;
          w_bit_idx_nxt = '0;
          w_tx_bit_nxt  = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
        end
      end
      TX_DATA: begin
        if (r_timer == c_bit_last) begin
          w_timer_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            if (PARITY_MODE != PARITY_NONE) begin
              w_state_nxt  = TX_PARITY;
              w_tx_bit_nxt = r_parity;
            end else begin
              w_state_nxt  = TX_STOP;
              w_tx_bit_nxt = 1'b1;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            w_tx_bit_nxt  = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (r_timer == c_bit_last) begin
          w_state_nxt  = TX_STOP;
          w_timer_nxt  = '0;
          w_tx_bit_nxt = 1'b1;
        end
      end
      TX_STOP: begin
        if (r_timer == c_stop_last) begin
          w_state_nxt  = TX_IDLE;
          w_timer_nxt  = '0;
          w_tx_bit_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = TX_IDLE;
        w_timer_nxt  = '0;
        w_tx_bit_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
      end
    endcase

    if (w_load) begin
      w_state_nxt  = TX_START;
      w_timer_nxt  = '0;
      w_shift_nxt  = w_fifo_dout;
      w_parity_nxt = (PARITY_MODE == PARITY_ODD) ? ~^w_fifo_dout : ^w_fifo_dout;
      w_tx_bit_nxt = 1'b0;
      w_busy_nxt   = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench; four instances cover 8N1, 8E1, 8O1, 8N2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [3:0] tvalid_v = '0;
  logic [7:0] tdata_v [4];
  wire  [3:0] tready_v;
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  wire  [2:0] level_v [4];

  logic [7:0] stream_data [6];
  int         push_edge [6];
  int         stall_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  for (genvar i = 0; i < 4; i++) begin : g_dut
    uart_tx_fifo #(
      .CLOCK_FREQ_HZ (1_000_000),
      .BAUD_RATE     (100_000),
      .FIFO_DEPTH    (4),
      .PARITY_MODE   ((i == 1) ? 1 : (i == 2) ? 2 : 0),
      .STOP_BITS     ((i == 3) ? 2 : 1)
    ) dut (
      .s_axis_aclk   (clk),
      .s_axis_areset (rst),
      .s_axis_tvalid (tvalid_v[i]),
      .s_axis_tdata  (tdata_v[i]),
      .s_axis_tready (tready_v[i]),
      .tx_bit        (tx_v[i]),
      .tx_busy       (busy_v[i]),
      .fifo_level    (level_v[i])
    );
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int sel, input logic [7:0] b);
    tvalid_v[sel] = 1'b1;
    tdata_v[sel]  = b;
    tick();
    tvalid_v[sel] = 1'b0;
  endtask

  // Called in the first cycle of a start bit; returns in the first cycle after the frame.
  task automatic frame_check(input int sel, input logic [7:0] b, input int pm, input int sb,
                             input string tag);
    int   len, slot, bad_bit, bad_busy;
    logic e;
    len      = (10 + ((pm != 0) ? 1 : 0) + (sb - 1)) * CPB;
    bad_bit  = 0;
    bad_busy = 0;
    for (int k = 0; k < len; k++) begin
      slot = k / CPB;
      if (slot == 0)                 e = 1'b0;
      else if (slot <= 8)            e = b[slot-1];
      else if (slot == 9 && pm == 1) e = ^b;
      else if (slot == 9 && pm == 2) e = ~^b;
      else                           e = 1'b1;
      if (tx_v[sel] !== e)       bad_bit++;
      if (busy_v[sel] !== 1'b1)  bad_busy++;
      tick();
    end
    check_value({tag, "_bits"}, bad_bit, 0);
    check_value({tag, "_busy"}, bad_busy, 0);
  endtask

  task automatic wait_start(input int sel, input string tag);
    int n = 0;
    while (tx_v[sel] !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_value({tag, "_start_timeout"}, n, 0);
  endtask

  // Holds tvalid on instance 0 and advances tdata only on an accepted handshake.
  task automatic drive_stream(input string tag);
    int  idx = 0;
    int  budget = 0;
    logic pushed;
    stall_cnt   = 0;
    tvalid_v[0] = 1'b1;
    tdata_v[0]  = stream_data[0];
    while (idx < 6 && budget < 400) begin
      pushed = 1'b0;
      if (tready_v[0]) begin
        push_edge[idx] = cyc + 1;
        idx++;
        pushed = 1'b1;
      end else begin
        stall_cnt++;
      end
      tick();
      if (pushed && idx == 5) begin
        check_value({tag, "_level_full"}, level_v[0], 4);
        check_value({tag, "_tready_full"}, tready_v[0], 0);
      end
      if (idx < 6) tdata_v[0] = stream_data[idx];
      else         tvalid_v[0] = 1'b0;
      budget++;
    end
    tvalid_v[0] = 1'b0;
    check_value({tag, "_accepted"}, idx, 6);
  endtask

  task automatic check_stream(input string tag);
    wait_start(0, tag);
    for (int i = 0; i < 6; i++) frame_check(0, stream_data[i], 0, 1, tag);
    check_value({tag, "_busy_end"}, busy_v[0], 0);
  endtask

  task automatic run_stream(input string tag);
    fork
      drive_stream(tag);
      check_stream(tag);
    join
    check_value({tag, "_sixth_push_edge"}, push_edge[5] - push_edge[0], 102);
    check_value({tag, "_fifth_push_edge"}, push_edge[4] - push_edge[0], 4);
    check_value({tag, "_stall_cycles"}, stall_cnt, 97);
    check_value({tag, "_level_end"}, level_v[0], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, lows;
    for (int i = 0; i < 4; i++) tdata_v[i] = 8'h00;

    // Reset state
    repeat (3) tick();
    check_value("rst_tx_bit", tx_v, 4'hF);
    check_value("rst_busy", busy_v, 4'h0);
    check_value("rst_level", level_v[0], 0);
    check_value("rst_tready", tready_v, 4'h0);
    rst = 1'b0;
    tick();
    check_value("post_rst_tready", tready_v, 4'hF);

    // 1: single 0xA5, 8N1
    push_byte(0, 8'hA5);
    check_value("t1_no_start_yet", tx_v[0], 1);
    check_value("t1_level_after_push", level_v[0], 1);
    tick();
    check_value("t1_level_after_pop", level_v[0], 0);
    frame_check(0, 8'hA5, 0, 1, "t1_a5");
    check_value("t1_busy_end", busy_v[0], 0);
    check_value("t1_tx_idle", tx_v[0], 1);

    // 2: 0x07 with even then odd parity
    push_byte(1, 8'h07);
    tick();
    frame_check(1, 8'h07, 1, 1, "t2_even");
    check_value("t2_even_busy_end", busy_v[1], 0);
    push_byte(2, 8'h07);
    tick();
    frame_check(2, 8'h07, 2, 1, "t2_odd");
    check_value("t2_odd_busy_end", busy_v[2], 0);

    // 3: held tvalid streaming 0x01..0x06
    for (int i = 0; i < 6; i++) stream_data[i] = 8'(i + 1);
    run_stream("t3");

    // 4: reset during DATA bit 3 of 0xF0 with two bytes queued
    push_byte(0, 8'hF0);
    push_byte(0, 8'hAA);
    push_byte(0, 8'h3C);
    repeat (44) tick();
    check_value("t4_bit3_value", tx_v[0], 0);
    check_value("t4_level_queued", level_v[0], 2);
    #2;
    rst = 1'b1;
    #1;
    check_value("t4_async_tx", tx_v[0], 1);
    check_value("t4_async_busy", busy_v[0], 0);
    check_value("t4_async_level", level_v[0], 0);
    check_value("t4_async_tready", tready_v[0], 0);
    tick();
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) lows++;
      tick();
    end
    check_value("t4_quiet_after_rst", lows, 0);
    push_byte(0, 8'h3C);
    tick();
    frame_check(0, 8'h3C, 0, 1, "t4_3c");
    check_value("t4_busy_end", busy_v[0], 0);
    check_value("t4_level_end", level_v[0], 0);

    // 5: two stop bits, 0xFF then 0x00 back to back
    push_byte(3, 8'hFF);
    push_byte(3, 8'h00);
    s1 = cyc;
    frame_check(3, 8'hFF, 0, 2, "t5_ff");
    s2 = cyc;
    check_value("t5_start_spacing", s2 - s1, 110);
    frame_check(3, 8'h00, 0, 2, "t5_00");
    check_value("t5_busy_end", busy_v[3], 0);

    // 6: 0x55 held while full must be accepted exactly once
    stream_data[0] = 8'h11;
    stream_data[1] = 8'h22;
    stream_data[2] = 8'h33;
    stream_data[3] = 8'h44;
    stream_data[4] = 8'h66;
    stream_data[5] = 8'h55;
    run_stream("t6");
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) lows++;
      tick();
    end
    check_value("t6_no_duplicate", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
